// File: rtl/core_ifu_fetch.sv
// rtl/core_ifu_fetch.sv - instruction fetch unit: PC, credit-limited fetch, instruction FIFO, redirect flush
// Optional feature macro: IFU_MISALIGN_TRAP_EN (adds fetch_misalign and a stop state on misaligned redirect targets)
module core_ifu_fetch #(
  parameter logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000,
  parameter int          BUF_DEPTH = 2,
  parameter int          PTR_W     = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_o,
  output logic [63:0] instr_pc,
  input  logic        redirect,
  input  logic [63:0] redirect_pc
`ifdef IFU_MISALIGN_TRAP_EN
  ,
  output logic        fetch_misalign
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    STOP  = 2'd2
  } state_t;

  localparam logic [PTR_W+1:0] DEPTH_W = BUF_DEPTH[PTR_W+1:0];

  state_t state, state_next;

  logic [63:0]    fetch_pc;
  logic [PTR_W:0] outstanding, outstanding_next;
  logic [PTR_W:0] drop_cnt, drop_next;
  logic [PTR_W:0] fifo_count;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W-1:0] pcq_rd, pcq_wr;
  logic           start_q;

  logic [31:0] data_mem [BUF_DEPTH];
  logic [63:0] pc_mem   [BUF_DEPTH];
  logic [63:0] pcq_mem  [BUF_DEPTH];

  logic [PTR_W+1:0] credit_used;
  logic             req_fire;
  logic             resp_fire;
  logic             resp_drop;
  logic             push;
  logic             pop;
  logic             misalign_hit;
  logic [63:0]      target_pc;

  // Requests are throttled so that every in-flight word already owns a FIFO slot.
  assign credit_used    = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req_valid = !rst && !start_q && (state == RUN) && !redirect && (credit_used < DEPTH_W);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses with nothing outstanding belong to requests abandoned by reset.
  assign resp_fire = !rst && imem_resp_valid && (outstanding != '0);
  assign resp_drop = resp_fire && (drop_cnt != '0);
  assign push      = resp_fire && !resp_drop && !redirect;

  assign instr_valid = !rst && (fifo_count != '0);
  assign pop         = instr_valid && instr_ready && !redirect;
  assign instr_o     = instr_valid ? data_mem[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr] : '0;

  assign target_pc = {redirect_pc[63:2], 2'b00};

`ifdef IFU_MISALIGN_TRAP_EN
  assign misalign_hit = redirect && (redirect_pc[1:0] != 2'b00);
`else
  logic unused_pc_bits;
  assign unused_pc_bits = ^redirect_pc[1:0];
  assign misalign_hit   = 1'b0;
`endif

  // Outstanding count and stale-response budget for the coming cycle.
  always_comb begin
    outstanding_next = outstanding;
    if (req_fire && !resp_fire) begin
      outstanding_next = outstanding + 1'b1;
    end else if (!req_fire && resp_fire) begin
      outstanding_next = outstanding - 1'b1;
    end
    drop_next = drop_cnt;
    if (redirect) begin
      drop_next = outstanding_next;
    end else if (resp_drop) begin
      drop_next = drop_cnt - 1'b1;
    end
  end

  // Next-state logic: FLUSH lasts exactly as long as stale responses remain.
  always_comb begin
    state_next = state;
    case (state)
      RUN, FLUSH: begin
        if (misalign_hit) begin
          state_next = STOP;
        end else if (redirect) begin
          state_next = (outstanding_next != '0) ? FLUSH : RUN;
        end else if ((state == FLUSH) && (drop_next == '0)) begin
          state_next = RUN;
        end
      end
      STOP:    state_next = STOP;
      default: state_next = RUN;
    endcase
  end

  // Control state: PC, counters, queue pointers; redirect clears both queues.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      fifo_count  <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      pcq_rd      <= '0;
      pcq_wr      <= '0;
      start_q     <= 1'b1;
    end else begin
      state       <= state_next;
      outstanding <= outstanding_next;
      drop_cnt    <= drop_next;
      start_q     <= 1'b0;
      if (redirect) begin
        fetch_pc   <= target_pc;
        fifo_count <= '0;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        pcq_rd     <= '0;
        pcq_wr     <= '0;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + 64'd4;
          pcq_wr   <= pcq_wr + 1'b1;
        end
        if (resp_fire && !resp_drop) begin
          pcq_rd <= pcq_rd + 1'b1;
        end
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (push && !pop) begin
          fifo_count <= fifo_count + 1'b1;
        end else if (!push && pop) begin
          fifo_count <= fifo_count - 1'b1;
        end
      end
    end
  end

  // Storage: PC captured at request time, paired with its word on response.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      pcq_mem[pcq_wr] <= fetch_pc;
    end
    if (push) begin
      data_mem[wr_ptr] <= imem_resp_data;
      pc_mem[wr_ptr]   <= pcq_mem[pcq_rd];
    end
  end

`ifdef IFU_MISALIGN_TRAP_EN
  // Sticky trap flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_misalign <= 1'b0;
    end else if (misalign_hit) begin
      fetch_misalign <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_core_ifu_fetch.sv
// tb/tb_core_ifu_fetch.sv - self-checking bench for core_ifu_fetch with queue-level reference model
module tb_core_ifu_fetch;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_o;
  logic [63:0] instr_pc;
  logic        redirect;
  logic [63:0] redirect_pc;
`ifdef IFU_MISALIGN_TRAP_EN
  logic        fetch_misalign;
`endif

  always #5 clk = ~clk;

  core_ifu_fetch dut (
    .clk(clk),
    .rst(rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_o(instr_o),
    .instr_pc(instr_pc),
    .redirect(redirect),
    .redirect_pc(redirect_pc)
`ifdef IFU_MISALIGN_TRAP_EN
    ,
    .fetch_misalign(fetch_misalign)
`endif
  );

  typedef struct { logic [63:0] addr; int due; } mreq_t;
  typedef struct { logic [63:0] pc; bit stale; } infl_t;
  typedef struct { logic [31:0] data; logic [63:0] pc; } ins_t;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int lat   = 1;

  mreq_t       mq[$];
  logic [63:0] alog[$];
  ins_t        dlog[$];

  logic [63:0] m_pc = RESET_PC;
  infl_t       m_infl[$];
  ins_t        m_buf[$];
  bit          m_first = 1'b1;
  bit          m_stop  = 1'b0;
  bit          m_mis   = 1'b0;

  function automatic logic [31:0] mdata(input logic [63:0] a);
    return {3'b000, a[23:2], 7'h13};
  endfunction

  function automatic logic [63:0] a_at(input int i);
    if (i < alog.size()) return alog[i];
    return 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] dpc_at(input int i);
    if (i < dlog.size()) return dlog[i].pc;
    return 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] ddata_at(input int i);
    if (i < dlog.size()) return {32'h0, dlog[i].data};
    return 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_and_update();
    logic  exp_rv, exp_iv, stale_pending;
    infl_t fl;
    stale_pending = 1'b0;
    foreach (m_infl[i]) if (m_infl[i].stale) stale_pending = 1'b1;
    exp_rv = !rst && !m_first && !m_stop && !redirect && !stale_pending &&
             ((m_infl.size() + m_buf.size()) < DEPTH);
    exp_iv = !rst && (m_buf.size() > 0);

    chk("imem_req_valid", {63'h0, imem_req_valid}, {63'h0, exp_rv});
    if (exp_rv) chk("imem_req_addr", imem_req_addr, m_pc);
    chk("instr_valid", {63'h0, instr_valid}, {63'h0, exp_iv});
    if (exp_iv) begin
      chk("instr_o", {32'h0, instr_o}, {32'h0, m_buf[0].data});
      chk("instr_pc", instr_pc, m_buf[0].pc);
    end else if (rst || m_first) begin
      chk("instr_o_zero", {32'h0, instr_o}, 64'h0);
      chk("instr_pc_zero", instr_pc, 64'h0);
    end
`ifdef IFU_MISALIGN_TRAP_EN
    if (!rst) chk("fetch_misalign", {63'h0, fetch_misalign}, {63'h0, m_mis});
`endif

    if (imem_req_valid && imem_req_ready) begin
      mq.push_back('{imem_req_addr, cyc + lat});
      alog.push_back(imem_req_addr);
    end
    if (!rst && instr_valid && instr_ready) dlog.push_back('{instr_o, instr_pc});

    if (rst) begin
      m_pc = RESET_PC;
      m_infl.delete();
      m_buf.delete();
      m_first = 1'b1;
      m_stop  = 1'b0;
      m_mis   = 1'b0;
    end else begin
      m_first = 1'b0;
      if (exp_iv && instr_ready) m_buf.delete(0);
      if (imem_resp_valid && (m_infl.size() > 0)) begin
        fl = m_infl[0];
        m_infl.delete(0);
        if (!fl.stale) m_buf.push_back('{imem_resp_data, fl.pc});
      end
      if (exp_rv && imem_req_ready) begin
        m_infl.push_back('{m_pc, 1'b0});
        m_pc = m_pc + 64'd4;
      end
      if (redirect) begin
        m_buf.delete();
        foreach (m_infl[i]) m_infl[i].stale = 1'b1;
`ifdef IFU_MISALIGN_TRAP_EN
        if (redirect_pc[1:0] != 2'b00) begin
          m_stop = 1'b1;
          m_mis  = 1'b1;
        end
`endif
        m_pc = {redirect_pc[63:2], 2'b00};
      end
    end
  endtask

  task automatic step();
    if ((mq.size() > 0) && (mq[0].due <= cyc)) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mdata(mq[0].addr);
      mq.delete(0);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
    #2;
    check_and_update();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    redirect = 1'b0;
    run(3);
    rst = 1'b0;
    alog.delete();
    dlog.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int stale_n;
    logic [15:0] pat;
    rst = 1'b1; imem_req_ready = 1'b1; instr_ready = 1'b1;
    redirect = 1'b0; redirect_pc = 64'h0;
    imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    @(negedge clk);

    // Basic streaming with a one-cycle memory.
    lat = 1;
    do_reset();
    run(12);
    chk("p1_addr0", a_at(0), 64'h8000_0000);
    chk("p1_addr1", a_at(1), 64'h8000_0004);
    chk("p1_pc0", dpc_at(0), 64'h8000_0000);
    chk("p1_data0", ddata_at(0), 64'h13);
    chk("p1_pc1", dpc_at(1), 64'h8000_0004);
    chk("p1_data1", ddata_at(1), 64'h93);

    // Decode stalled: credit limit holds requests at BUF_DEPTH.
    instr_ready = 1'b0;
    do_reset();
    run(12);
    chk("p2_req_count", alog.size(), 64'd2);
    #1 chk("p2_stalled_req_valid", {63'h0, imem_req_valid}, 64'h0);
    instr_ready = 1'b1;
    run(8);
    chk("p2_resume_addr", a_at(2), 64'h8000_0008);

    // Redirect with two outstanding requests.
    lat = 3;
    do_reset();
    run(3);
    redirect = 1'b1; redirect_pc = 64'h8000_1000;
    step();
    redirect = 1'b0;
    run(20);
    chk("p3_first_new_addr", a_at(2), 64'h8000_1000);
    chk("p3_first_pc", dpc_at(0), 64'h8000_1000);
    chk("p3_first_data", ddata_at(0), 64'h20013);

    // Second redirect while still flushing.
    do_reset();
    run(3);
    redirect = 1'b1; redirect_pc = 64'h8000_1000;
    step();
    redirect_pc = 64'h8000_2000;
    step();
    redirect = 1'b0;
    run(20);
    stale_n = 0;
    foreach (dlog[i]) if (dlog[i].pc < 64'h8000_2000) stale_n++;
    chk("p4_no_stale", stale_n, 64'd0);
    chk("p4_first_new_addr", a_at(2), 64'h8000_2000);
    chk("p4_first_pc", dpc_at(0), 64'h8000_2000);

    // Reset with one request in flight; its response lands during reset.
    do_reset();
    run(2);
    rst = 1'b1;
    alog.delete();
    dlog.delete();
    run(4);
    rst = 1'b0;
    run(12);
    chk("p5_restart_addr", a_at(0), RESET_PC);
    chk("p5_first_pc", dpc_at(0), RESET_PC);
    chk("p5_first_data", ddata_at(0), 64'h13);

    // Mixed backpressure on both channels plus a redirect.
    lat = 2;
    do_reset();
    pat = 16'b1011_0010_1110_0110;
    for (int i = 0; i < 40; i++) begin
      instr_ready    = pat[i % 16];
      imem_req_ready = pat[(i + 5) % 16];
      redirect       = (i == 17);
      redirect_pc    = 64'h8000_3000;
      step();
    end
    redirect = 1'b0; instr_ready = 1'b1; imem_req_ready = 1'b1;
    run(10);

    // Misaligned redirect target.
    lat = 1;
    do_reset();
    run(2);
    redirect = 1'b1; redirect_pc = 64'h8000_0102;
    step();
    redirect = 1'b0;
    run(8);
`ifdef IFU_MISALIGN_TRAP_EN
    chk("p6_misalign_set", {63'h0, fetch_misalign}, 64'h1);
    chk("p6_no_more_reqs", alog.size(), 64'd1);
    do_reset();
    #1 chk("p6_misalign_cleared", {63'h0, fetch_misalign}, 64'h0);
`else
    chk("p6_aligned_addr", a_at(1), 64'h8000_0100);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
